// File: rtl/expected_delay_stage.sv
// One valid/data register pair of the expected-value delay line.
// Data only loads on valid, so the word stays put across invalid cycles.
module expected_delay_stage #(
    parameter int unsigned EXPECTED_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic                     in_valid,
    input  logic [EXPECTED_BITS-1:0] in_data,
    output logic                     out_valid,
    output logic [EXPECTED_BITS-1:0] out_data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (cke) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/expected_delay_line.sv
// Delay line carrying an expected word and its valid flag through LATENCY
// clock-enabled stages, time-aligned with the operator under check.
module expected_delay_line #(
    parameter int unsigned LATENCY       = 1,
    parameter int unsigned EXPECTED_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic [EXPECTED_BITS-1:0] s_data,
    input  logic                     s_valid,
    output logic [EXPECTED_BITS-1:0] m_data,
    output logic                     m_valid
);

    generate
        if (LATENCY == 0) begin : g_comb
            // Pure wire: clock, reset and enable have no effect here.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, cke};
            assign m_data      = s_data;
            assign m_valid     = s_valid;
        end else begin : g_pipe
            logic                     vld_pipe [LATENCY+1];
            logic [EXPECTED_BITS-1:0] dat_pipe [LATENCY+1];

            assign vld_pipe[0] = s_valid;
            assign dat_pipe[0] = s_data;

            for (genvar i = 0; i < LATENCY; i++) begin : g_stage
                expected_delay_stage #(
                    .EXPECTED_BITS(EXPECTED_BITS)
                ) u_stage (
                    .clk      (clk),
                    .reset    (reset),
                    .cke      (cke),
                    .in_valid (vld_pipe[i]),
                    .in_data  (dat_pipe[i]),
                    .out_valid(vld_pipe[i+1]),
                    .out_data (dat_pipe[i+1])
                );
            end

            assign m_valid = vld_pipe[LATENCY];
            assign m_data  = dat_pipe[LATENCY];
        end
    endgenerate

endmodule

// File: tb/tb_expected_delay_line.sv
// Scoreboard bench: several line configurations share one stimulus stream;
// each enabled valid sample is queued with the enabled-edge index it must emerge at.
module tb_expected_delay_line;

    logic        clk;
    logic        reset;
    logic        cke;
    logic        s_valid;
    logic [32:0] s_data;

    logic [7:0]  md_l0;
    logic        mv_l0;
    logic [32:0] md_w33;
    logic [7:0]  md_l2, md_l3, md_l4;
    logic        mv [4];
    logic [32:0] md [4];

    localparam int LAT [4] = '{1, 2, 3, 4};

    expected_delay_line #(.LATENCY(0), .EXPECTED_BITS(8)) u_l0 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(md_l0), .m_valid(mv_l0));
    expected_delay_line #(.LATENCY(1), .EXPECTED_BITS(33)) u_l1 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .m_data(md_w33), .m_valid(mv[0]));
    expected_delay_line #(.LATENCY(2), .EXPECTED_BITS(8)) u_l2 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(md_l2), .m_valid(mv[1]));
    expected_delay_line #(.LATENCY(3), .EXPECTED_BITS(8)) u_l3 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(md_l3), .m_valid(mv[2]));
    expected_delay_line #(.LATENCY(4), .EXPECTED_BITS(8)) u_l4 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(md_l4), .m_valid(mv[3]));

    assign md[0] = md_w33;
    assign md[1] = {25'd0, md_l2};
    assign md[2] = {25'd0, md_l3};
    assign md[3] = {25'd0, md_l4};

    // Scoreboard: written only by stimulus (push), read by the monitor via rd[].
    logic [32:0] qd   [4][$];
    int          qdue [4][$];
    int          ecount;
    bit          done;

    int checks;
    int errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus; the enabled edge that consumes it is recorded.
    task automatic step(input logic v, input logic [32:0] d, input logic ce);
        s_valid = v;
        s_data  = d;
        cke     = ce;
        @(posedge clk);
        if (reset && ce) begin
            ecount++;
            if (v) begin
                for (int i = 0; i < 4; i++) begin
                    qd[i].push_back(i == 0 ? d : {25'd0, d[7:0]});
                    qdue[i].push_back(ecount + LAT[i] - 1);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 33'h0, 1'b1);
    endtask

    // Called right after step() returns, i.e. while clk is high.
    task automatic assert_reset();
        reset  = 1'b0;
        ecount = 0;
    endtask

    initial begin : monitor
        int          rd [4];
        logic [32:0] last [4];
        logic        exp_v;
        logic [32:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            rd[i]   = 0;
            last[i] = '0;
        end
        while (!done) begin
            @(negedge clk or negedge reset);
            if (clk === 1'b1) begin
                // Reset fell mid-cycle: outputs must clear without any clock.
                #1;
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("async_rst_valid[L%0d]", LAT[i]), {32'd0, mv[i]}, 33'd0);
                    check($sformatf("async_rst_data[L%0d]", LAT[i]), md[i], 33'd0);
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (!reset) begin
                        rd[i]   = qd[i].size();
                        last[i] = '0;
                    end
                    while (rd[i] < qd[i].size() && qdue[i][rd[i]] < ecount) begin
                        last[i] = qd[i][rd[i]];
                        rd[i]++;
                    end
                    exp_v = (rd[i] < qd[i].size()) && (qdue[i][rd[i]] == ecount);
                    exp_d = exp_v ? qd[i][rd[i]] : last[i];
                    check($sformatf("m_valid[L%0d]", LAT[i]), {32'd0, mv[i]}, {32'd0, exp_v});
                    check($sformatf("m_data[L%0d]", LAT[i]), md[i], exp_d);
                end
                check("m_valid[L0]", {32'd0, mv_l0}, {32'd0, s_valid});
                check("m_data[L0]", {25'd0, md_l0}, {25'd0, s_data[7:0]});
            end
        end
    end

    initial begin : stimulus
        logic [32:0] rd_data;
        done    = 1'b0;
        checks  = 0;
        errors  = 0;
        ecount  = 0;
        reset   = 1'b0;
        cke     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        step(1'b0, 33'h0, 1'b1);
        step(1'b1, 33'h0_0000_00EE, 1'b1);   // ignored while in reset
        reset = 1'b1;

        step(1'b1, 33'h0_0000_00A5, 1'b1);
        idle(5);
        step(1'b1, 33'h0_0000_0012, 1'b1);
        idle(6);
        step(1'b1, 33'h0_0000_0001, 1'b1);
        step(1'b1, 33'h0_0000_0002, 1'b1);
        step(1'b1, 33'h0_0000_0003, 1'b1);
        idle(6);
        step(1'b1, 33'h0_0000_007F, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 33'h0_0000_0055 + 33'(k), 1'b0);
        idle(6);
        step(1'b1, 33'h1_8000_0001, 1'b1);
        idle(5);

        // Reset mid-stream with samples in flight.
        step(1'b1, 33'h0_0000_0031, 1'b1);
        step(1'b1, 33'h0_0000_0032, 1'b1);
        step(1'b1, 33'h0_0000_0033, 1'b1);
        assert_reset();
        step(1'b1, 33'h0_0000_0044, 1'b1);
        step(1'b0, 33'h0, 1'b1);
        reset = 1'b1;
        idle(8);

        for (int n = 0; n < 600; n++) begin
            rd_data = {1'($urandom_range(1, 0)), 32'($urandom())};
            step(1'($urandom_range(1, 0)), rd_data, ($urandom_range(9, 0) < 8));
            if ($urandom_range(99, 0) == 0) begin
                assert_reset();
                step(1'($urandom_range(1, 0)), rd_data, 1'b1);
                reset = 1'b1;
            end
        end
        idle(8);

        done = 1'b1;
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
